// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: command codes,
// FSM state encoding and per-target address strides.
package prog_loader_pkg;

  localparam logic [7:0] CMD_IMEM  = 8'h00;
  localparam logic [7:0] CMD_DMEM  = 8'h01;
  localparam logic [7:0] CMD_START = 8'hFF;

  localparam int IMEM_STRIDE = 4;
  localparam int DMEM_STRIDE = 8;

  typedef enum logic [2:0] {
    CMD,
    CNT_LO,
    CNT_HI,
    DATA,
    RUN,
    ERR
  } state_t;

  // Byte address of a word index for the selected target, zero-extended.
  function automatic logic [63:0] word_addr(input logic [15:0] index, input logic dmem);
    if (dmem) return 64'(index) * 64'(DMEM_STRIDE);
    else      return 64'(index) * 64'(IMEM_STRIDE);
  endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Little-endian word assembler: collects bytes into a 64-bit register and
// flags the byte that completes a word of (last_idx + 1) bytes.
module prog_loader_byte_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  input  logic [2:0]  last_idx,
  output logic        last,
  output logic [63:0] word
);

  logic [2:0]  byte_cnt;
  logic [63:0] acc;

  // word already contains the byte being offered, so the completing byte
  // can be captured by the caller in the same handshake cycle.
  always_comb begin
    word = (byte_cnt == 3'd0) ? 64'd0 : acc;
    word = word | ({56'd0, byte_in} << {byte_cnt, 3'b000});
    last = accept && (byte_cnt == last_idx);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= 3'd0;
      acc      <= 64'd0;
    end else if (accept) begin
      acc      <= word;
      byte_cnt <= (byte_cnt == last_idx) ? 3'd0 : byte_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a byte-stream protocol, writes instruction/data memory
// words and releases the CPU on the start command.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [63:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [63:0] dmem_addr,
  output logic        dmem_wen,
  output logic [63:0] dmem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err,
  output logic [15:0] words_loaded
);

  // Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready;
  // rx_ready depends only on the current state, never on rx_valid.
  state_t      state, state_next;
  logic        fire, target_dmem, too_big;
  logic        asm_accept, asm_clear, asm_last;
  logic [2:0]  last_idx;
  logic [7:0]  cnt_lo;
  logic [15:0] count, n_words, index;
  logic [63:0] asm_word;

  assign rx_ready   = (state == CMD) || (state == CNT_LO) ||
                      (state == CNT_HI) || (state == DATA);
  assign fire       = rx_valid && rx_ready;
  assign count      = {rx_data, cnt_lo};
  assign too_big    = target_dmem ? (32'(count) > DMEM_WORDS)
                                  : (32'(count) > IMEM_WORDS);
  assign cpu_enable = (state == RUN);
  assign err        = (state == ERR);
  // The final write pulse lands after the FSM is back in CMD; keep busy up.
  assign busy       = (state == CNT_LO) || (state == CNT_HI) ||
                      (state == DATA) || imem_wen || dmem_wen;
  assign asm_accept = fire && (state == DATA);
  assign asm_clear  = fire && (state == CNT_HI);
  assign last_idx   = target_dmem ? 3'd7 : 3'd3;

  prog_loader_byte_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (asm_clear),
    .accept   (asm_accept),
    .byte_in  (rx_data),
    .last_idx (last_idx),
    .last     (asm_last),
    .word     (asm_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= CMD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      CMD: if (fire) begin
        if (rx_data == CMD_IMEM || rx_data == CMD_DMEM) state_next = CNT_LO;
        else if (rx_data == CMD_START)                   state_next = RUN;
        else                                             state_next = ERR;
      end
      CNT_LO: if (fire) state_next = CNT_HI;
      CNT_HI: if (fire) begin
        if (count == 16'd0) state_next = CMD;
        else if (too_big)   state_next = ERR;
        else                state_next = DATA;
      end
      DATA: if (asm_last && (index == n_words - 16'd1)) state_next = CMD;
      RUN:     state_next = RUN;
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_dmem  <= 1'b0;
      cnt_lo       <= 8'd0;
      n_words      <= 16'd0;
      index        <= 16'd0;
      words_loaded <= 16'd0;
      imem_wen     <= 1'b0;
      imem_addr    <= 64'd0;
      imem_wdata   <= 32'd0;
      dmem_wen     <= 1'b0;
      dmem_addr    <= 64'd0;
      dmem_wdata   <= 64'd0;
    end else begin
      imem_wen <= 1'b0;
      dmem_wen <= 1'b0;
      if (state == CMD && fire && (rx_data == CMD_IMEM || rx_data == CMD_DMEM))
        target_dmem <= (rx_data == CMD_DMEM);
      if (state == CNT_LO && fire)
        cnt_lo <= rx_data;
      if (state == CNT_HI && fire && !too_big) begin
        n_words      <= count;
        index        <= 16'd0;
        words_loaded <= 16'd0;
      end
      if (asm_last) begin
        if (target_dmem) begin
          dmem_wen   <= 1'b1;
          dmem_addr  <= word_addr(index, 1'b1);
          dmem_wdata <= asm_word;
        end else begin
          imem_wen   <= 1'b1;
          imem_addr  <= word_addr(index, 1'b0);
          imem_wdata <= asm_word[31:0];
        end
        index        <= index + 16'd1;
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: randomized byte streams, expected memory writes queued
// by the driver and matched by an independent write monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] imem_addr;
  logic        imem_wen;
  logic [31:0] imem_wdata;
  logic [63:0] dmem_addr;
  logic        dmem_wen;
  logic [63:0] dmem_wdata;
  logic        cpu_enable;
  logic        busy;
  logic        err;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int ipulses = 0;
  int dpulses = 0;

  // {is_dmem, byte address, data}
  logic [128:0] exp_q[$];
  logic [63:0]  load_words[$];

  prog_loader #(.IMEM_WORDS(512), .DMEM_WORDS(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_addr    (imem_addr),
    .imem_wen     (imem_wen),
    .imem_wdata   (imem_wdata),
    .dmem_addr    (dmem_addr),
    .dmem_wen     (dmem_wen),
    .dmem_wdata   (dmem_wdata),
    .cpu_enable   (cpu_enable),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && (imem_wen || dmem_wen)) begin
      logic [128:0] got, exp;
      checks++;
      if (imem_wen && dmem_wen) begin
        errors++;
        $display("FAIL both_wen imem_wen=%0b dmem_wen=%0b required one-hot", imem_wen, dmem_wen);
      end
      got = dmem_wen ? {1'b1, dmem_addr, dmem_wdata} : {1'b0, imem_addr, 32'd0, imem_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got=%h required none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL write got=%h required=%h", got, exp);
        end
      end
      if (dmem_wen) dpulses++;
      else          ipulses++;
    end
  end

  // Driver tasks
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    logic ok;
    int   tries;
    if (gaps && $urandom_range(0, 1) == 1) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    tries    = 0;
    forever begin
      ok = rx_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      tries++;
      if (tries >= 16) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout byte=%0h rx_ready=%0b required 1", b, rx_ready);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic poke(input logic [7:0] b, input int cycles);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Sends a load of load_words; abort_at >= 0 stops after that many data bytes.
  task automatic send_load(input bit dmem, input int n, input bit gaps, input int abort_at);
    int bpw;
    int sent;
    bpw  = dmem ? 8 : 4;
    sent = 0;
    send_byte(dmem ? 8'h01 : 8'h00, gaps);
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    for (int w = 0; w < n; w++) begin
      logic [63:0] word;
      word = load_words[w];
      if (abort_at < 0 || (w + 1) * bpw <= abort_at)
        exp_q.push_back({dmem, 64'(w) * 64'(bpw), dmem ? word : {32'd0, word[31:0]}});
      for (int k = 0; k < bpw; k++) begin
        if (abort_at >= 0 && sent >= abort_at) return;
        send_byte(word[8*k +: 8], gaps);
        sent++;
      end
    end
  endtask

  task automatic fill_random(input int n);
    load_words.delete();
    for (int i = 0; i < n; i++) load_words.push_back({$urandom(), $urandom()});
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rx_ready", rx_ready, 1);
    check("rst_flags", {imem_wen, dmem_wen, cpu_enable, busy, err}, 0);
    check("rst_words_loaded", words_loaded, 0);
    check("rst_addrs", imem_addr | dmem_addr, 0);
    check("rst_wdata", dmem_wdata | {32'd0, imem_wdata}, 0);
    rst = 1'b0;
  endtask

  // Test sequence
  initial begin
    int ip0, dp0, n;
    bit dm;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Single IMEM word 0x13
    load_words = {64'h13};
    ip0 = ipulses;
    send_load(1'b0, 1, 1'b0, -1);
    check("single_busy_on_pulse", busy, 1);
    @(posedge clk); #1;
    check("single_words_loaded", words_loaded, 1);
    check("single_busy_after", busy, 0);
    check("single_back_in_cmd", rx_ready, 1);
    check("single_ipulses", ipulses - ip0, 1);

    // DMEM burst with gaps
    load_words = {64'h0807060504030201, 64'h100F0E0D0C0B0A09};
    ip0 = ipulses; dp0 = dpulses;
    send_load(1'b1, 2, 1'b1, -1);
    repeat (2) @(posedge clk); #1;
    check("dmem_pulses", dpulses - dp0, 2);
    check("dmem_no_imem", ipulses - ip0, 0);
    check("dmem_words_loaded", words_loaded, 2);

    // Random loads to both targets
    for (int it = 0; it < 8; it++) begin
      dm = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 6);
      fill_random(n);
      send_load(dm, n, 1'($urandom_range(0, 1)), -1);
      @(posedge clk); #1;
      check("rand_words_loaded", words_loaded, 64'(n));
    end

    // Full-depth IMEM at full rate
    fill_random(512);
    send_load(1'b0, 512, 1'b0, -1);
    @(posedge clk); #1;
    check("full_words_loaded", words_loaded, 512);

    // Start after a load
    fill_random(1);
    send_load(1'b0, 1, 1'b0, -1);
    send_byte(8'hFF, 1'b0);
    check("start_cpu_enable", cpu_enable, 1);
    check("start_rx_ready", rx_ready, 0);
    ip0 = ipulses; dp0 = dpulses;
    poke(8'h00, 4);
    repeat (2) @(posedge clk); #1;
    check("run_no_writes", (ipulses - ip0) + (dpulses - dp0), 0);
    check("run_stays", {cpu_enable, err}, 2'b10);
    do_reset();

    // Bad command byte
    send_byte(8'h42, 1'b0);
    check("badcmd_err", err, 1);
    check("badcmd_rx_ready", rx_ready, 0);
    poke(8'hFF, 2);
    check("badcmd_cpu_enable", cpu_enable, 0);
    do_reset();

    // Over-depth counts
    ip0 = ipulses; dp0 = dpulses;
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    check("imem513_err", err, 1);
    poke(8'h11, 6);
    check("imem513_no_writes", ipulses - ip0, 0);
    do_reset();
    send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h04, 1'b0);
    check("dmem1025_err", err, 1);
    do_reset();

    // Zero count after a real load, then start
    fill_random(1);
    send_load(1'b0, 1, 1'b0, -1);
    @(posedge clk); #1;
    ip0 = ipulses;
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    check("zero_words_loaded", words_loaded, 0);
    check("zero_back_in_cmd", {rx_ready, busy}, 2'b10);
    send_byte(8'hFF, 1'b0);
    check("zero_cpu_enable", cpu_enable, 1);
    check("zero_no_writes", ipulses - ip0, 0);
    do_reset();

    // Reset in the middle of the second word of a 3-word load
    fill_random(3);
    send_load(1'b0, 3, 1'b0, 6);
    do_reset();
    fill_random(1);
    send_load(1'b0, 1, 1'b1, -1);
    @(posedge clk); #1;
    check("after_abort_words_loaded", words_loaded, 1);

    repeat (3) @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
